// File: rtl/vga_pattern_sequencer.sv
// Test-pattern sequencer for the 6-bit VGA path: four selectable patterns, frame-aligned stepping,
// run/pause control, one-cycle registered pixel with matching sync delay. Optional macro: VGA_BORDER_EN.
module vga_pattern_sequencer #(
  parameter int HOLD_FRAMES     = 60,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] x_px,
  input  logic [9:0] y_px,
  input  logic       activevideo,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       btn_next,
  input  logic       btn_pause,
  output logic [5:0] rgb,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [1:0] pattern_idx,
  output logic       paused
);

  localparam int              HW        = $clog2(HOLD_FRAMES) + 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic            SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
  localparam logic [9:0]      X_END     = 10'(H_ACTIVE);
  localparam logic [9:0]      Y_END     = 10'(V_ACTIVE);

  typedef enum logic {S_RUN, S_PAUSE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_btn_next_d;
  logic          r_btn_pause_d;
  logic          r_pending;
  logic [HW-1:0] r_hold;
  logic [7:0]    r_anim;
  logic [1:0]    r_idx;
  logic [5:0]    r_rgb;
  logic          r_hs;
  logic          r_vs;

  logic          w_frame;
  logic          w_next_edge;
  logic          w_pause_edge;
  logic          w_visible;
  logic          w_border;
  logic [5:0]    w_pat;
  logic [5:0]    w_pix;

  // The delayed vsync doubles as the previous-sample register for frame detection.
  assign w_frame      = (vsync_in ^ SYNC_IDLE) & ~(r_vs ^ SYNC_IDLE);
  assign w_next_edge  = btn_next & ~r_btn_next_d;
  assign w_pause_edge = btn_pause & ~r_btn_pause_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_RUN;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_pause_edge) w_state_next = (r_state == S_RUN) ? S_PAUSE : S_RUN;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_btn_next_d  <= 1'b0;
      r_btn_pause_d <= 1'b0;
      r_pending     <= 1'b0;
      r_hold        <= '0;
      r_anim        <= 8'd0;
      r_idx         <= 2'd0;
    end else begin
      r_btn_next_d  <= btn_next;
      r_btn_pause_d <= btn_pause;
      if (w_frame) begin
        r_pending <= 1'b0;
        if (r_state == S_RUN) r_anim <= r_anim + 8'd1;
        // A pending step and an auto-advance landing together still move by one.
        if (r_pending) begin
          r_idx  <= r_idx + 2'd1;
          r_hold <= '0;
        end else if (r_state == S_RUN) begin
          if (r_hold == HOLD_LAST) begin
            r_hold <= '0;
            r_idx  <= r_idx + 2'd1;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
      end else if (w_next_edge) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_pat = 6'd0;
    case (r_idx)
      2'd0:    w_pat = {y_px > 10'd300, y_px > 10'd150, x_px > 10'd400, x_px > 10'd200, 2'b00};
      2'd1:    w_pat = {{2{x_px[8]}}, {2{x_px[7]}}, {2{x_px[6]}}};
      2'd2:    w_pat = (x_px[5] ^ y_px[5]) ? 6'h3F : 6'h00;
      default: w_pat = {y_px[7:6], x_px[7:6], r_anim[7:6]};
    endcase
  end

  // Guards against a sync generator flagging activevideo outside the configured raster.
  assign w_visible = activevideo & (x_px < X_END) & (y_px < Y_END);

`ifdef VGA_BORDER_EN
  assign w_border = (x_px == 10'd0) | (x_px == X_END - 10'd1) |
                    (y_px == 10'd0) | (y_px == Y_END - 10'd1);
`else
  assign w_border = 1'b0;
`endif

  assign w_pix = w_border ? 6'h3F : w_pat;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rgb <= 6'd0;
      r_hs  <= SYNC_IDLE;
      r_vs  <= SYNC_IDLE;
    end else begin
      r_rgb <= w_visible ? w_pix : 6'd0;
      r_hs  <= hsync_in;
      r_vs  <= vsync_in;
    end
  end

  assign rgb         = r_rgb;
  assign hsync_out   = r_hs;
  assign vsync_out   = r_vs;
  assign pattern_idx = r_idx;
  assign paused      = (r_state == S_PAUSE);

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Scoreboard bench for vga_pattern_sequencer (HOLD_FRAMES=2, active-low syncs).
module tb_vga_pattern_sequencer;

  localparam int HF = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic [9:0] x_px, y_px;
  logic       activevideo, hsync_in, vsync_in, btn_next, btn_pause;
  logic [5:0] rgb;
  logic       hsync_out, vsync_out, paused;
  logic [1:0] pattern_idx;

  always #5 clk = ~clk;

  vga_pattern_sequencer #(
    .HOLD_FRAMES(HF), .H_ACTIVE(640), .V_ACTIVE(480), .SYNC_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .resetn(resetn), .x_px(x_px), .y_px(y_px), .activevideo(activevideo),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .btn_next(btn_next), .btn_pause(btn_pause),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .pattern_idx(pattern_idx), .paused(paused)
  );

  typedef struct {
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
    logic [1:0] idx;
    logic       paused;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int         m_hold;
  logic [1:0] m_idx;
  logic       m_pending, m_paused;
  logic [7:0] m_anim;
  logic       m_vs_prev, m_bn_prev, m_bp_prev;

  function automatic logic [5:0] model_rgb(input logic [9:0] x, input logic [9:0] y,
                                           input logic av, input logic [1:0] idx,
                                           input logic [7:0] anim);
    logic [2:0] bars;
    if (!av) return 6'd0;
`ifdef VGA_BORDER_EN
    if (x == 0 || x == 639 || y == 0 || y == 479) return 6'h3F;
`endif
    bars = x[8:6];
    case (idx)
      2'd0:    return {y > 300, y > 150, x > 400, x > 200, 2'b00};
      2'd1:    return {bars[2], bars[2], bars[1], bars[1], bars[0], bars[0]};
      2'd2:    return (x[5] != y[5]) ? 6'h3F : 6'h00;
      default: return {y[7:6], x[7:6], anim[7:6]};
    endcase
  endfunction

  task automatic model_reset();
    m_hold = 0; m_idx = 2'd0; m_pending = 1'b0; m_paused = 1'b0; m_anim = 8'd0;
    m_vs_prev = 1'b1; m_bn_prev = 1'b0; m_bp_prev = 1'b0;
  endtask

  // Drives one clock of inputs and pushes the outputs expected after the next rising edge.
  task automatic cycle(input logic [9:0] x, input logic [9:0] y, input logic av,
                       input logic hs, input logic vs, input logic bn, input logic bp);
    exp_t e;
    logic frame, nedge, pedge;
    @(negedge clk);
    x_px = x; y_px = y; activevideo = av; hsync_in = hs; vsync_in = vs;
    btn_next = bn; btn_pause = bp;
    e.rgb = model_rgb(x, y, av, m_idx, m_anim);
    e.hs  = hs;
    e.vs  = vs;
    frame = (vs == 1'b0) && m_vs_prev;
    nedge = bn && !m_bn_prev;
    pedge = bp && !m_bp_prev;
    if (frame) begin
      if (!m_paused) m_anim = m_anim + 8'd1;
      if (m_pending) begin
        m_idx = m_idx + 2'd1; m_hold = 0;
      end else if (!m_paused) begin
        if (m_hold == HF - 1) begin m_hold = 0; m_idx = m_idx + 2'd1; end
        else m_hold = m_hold + 1;
      end
      m_pending = 1'b0;
    end else if (nedge) begin
      m_pending = 1'b1;
    end
    if (pedge) m_paused = !m_paused;
    m_vs_prev = vs; m_bn_prev = bn; m_bp_prev = bp;
    e.idx = m_idx; e.paused = m_paused;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (resetn && sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if ({rgb, hsync_out, vsync_out, pattern_idx, paused} !==
          {e.rgb, e.hs, e.vs, e.idx, e.paused}) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got rgb=%h hs=%b vs=%b idx=%0d paused=%b, want rgb=%h hs=%b vs=%b idx=%0d paused=%b",
                 $time, rgb, hsync_out, vsync_out, pattern_idx, paused,
                 e.rgb, e.hs, e.vs, e.idx, e.paused);
      end
    end
  end

  task automatic settle();
    @(posedge clk); #2;
  endtask

  task automatic pixel(input logic bn, input logic bp);
    cycle(10'($urandom_range(639)), 10'($urandom_range(479)), 1'($urandom_range(3) != 0),
          1'($urandom_range(1)), 1'b1, bn, bp);
  endtask

  task automatic do_frame(input int npix);
    for (int i = 0; i < npix; i++) pixel(1'b0, 1'b0);
    cycle(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
  endtask

  task automatic pulse_next();
    pixel(1'b1, 1'b0);
    pixel(1'b0, 1'b0);
    settle();
  endtask

  task automatic pulse_pause();
    pixel(1'b0, 1'b1);
    pixel(1'b0, 1'b0);
    settle();
  endtask

  task automatic check_idx(input string name, input logic [1:0] want);
    n_tests++;
    if (pattern_idx !== want) begin
      n_fail++;
      $display("FAIL %s: pattern_idx=%0d want %0d", name, pattern_idx, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    x_px = 10'd0; y_px = 10'd0; activevideo = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    btn_next = 1'b0; btn_pause = 1'b0;
    sb.delete();
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++;
    if ({rgb, hsync_out, vsync_out, pattern_idx, paused} !== {6'd0, 1'b1, 1'b1, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: rgb=%h hs=%b vs=%b idx=%0d paused=%b want 00 1 1 0 0",
               rgb, hsync_out, vsync_out, pattern_idx, paused);
    end
  endtask

  task automatic test_autoadvance();
    logic [1:0] seq[8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_frame(3);
      check_idx($sformatf("autoadvance_frame%0d", i + 1), seq[i]);
    end
  endtask

  task automatic test_pattern0();
    do_reset();
    cycle(10'd401, 10'd151, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    n_tests++;
    if (rgb !== 6'b011100) begin
      n_fail++; $display("FAIL pattern0_401_151: rgb=%b want 011100", rgb);
    end
    cycle(10'd401, 10'd151, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    n_tests++;
    if (rgb !== 6'd0) begin
      n_fail++; $display("FAIL pattern0_blank: rgb=%b want 000000", rgb);
    end
  endtask

  task automatic test_pause_step();
    logic [1:0] base;
    pulse_pause();
    n_tests++;
    if (paused !== 1'b1) begin
      n_fail++; $display("FAIL pause_enter: paused=%b want 1", paused);
    end
    base = m_idx;
    pulse_next();
    for (int i = 0; i < 4; i++) pixel(1'b0, 1'b0);
    settle();
    check_idx("step_pending_midframe", base);
    pulse_next();
    check_idx("step_second_edge", base);
    do_frame(2);
    check_idx("step_on_frame", base + 2'd1);
    do_frame(2);
    check_idx("step_paused_after", base + 2'd1);
    pulse_pause();
    n_tests++;
    if (paused !== 1'b0) begin
      n_fail++; $display("FAIL pause_exit: paused=%b want 0", paused);
    end
  endtask

  task automatic test_pending_on_advance();
    logic [1:0] base;
    if (m_hold != 1) do_frame(2);
    base = m_idx;
    pulse_next();
    do_frame(2);
    check_idx("coincide_single_step", base + 2'd1);
    do_frame(2);
    check_idx("coincide_counter_cleared", base + 2'd1);
    do_frame(2);
    check_idx("coincide_next_advance", base + 2'd2);
  endtask

  task automatic test_pause_freeze();
    logic [1:0] base;
    if (m_hold != 1) do_frame(2);
    base = m_idx;
    pulse_pause();
    for (int i = 0; i < 5; i++) begin
      do_frame(2);
      check_idx($sformatf("freeze_frame%0d", i + 1), base);
    end
    pulse_pause();
    do_frame(2);
    check_idx("resume_same_counter", base + 2'd1);
  endtask

  task automatic test_anim();
    for (int i = 0; i < 140; i++) do_frame(4);
  endtask

  task automatic test_reset_mid();
    pulse_pause();
    for (int i = 0; i < 4 && m_idx != 2'd3; i++) begin
      pulse_next();
      do_frame(1);
    end
    check_idx("reach_pattern3", 2'd3);
    pulse_next();
    cycle(10'd200, 10'd200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(10'd200, 10'd200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    resetn = 1'b0;
    #1;
    n_tests++;
    if ({rgb, hsync_out, vsync_out, pattern_idx, paused} !== {6'd0, 1'b1, 1'b1, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_midframe: rgb=%h hs=%b vs=%b idx=%0d paused=%b want 00 1 1 0 0",
               rgb, hsync_out, vsync_out, pattern_idx, paused);
    end
    sb.delete();
    model_reset();
    x_px = 10'd0; y_px = 10'd0; activevideo = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    do_frame(2);
    check_idx("reset_cleared_pending", 2'd0);
  endtask

`ifdef VGA_BORDER_EN
  task automatic test_border();
    logic [9:0] xs[3] = '{10'd0, 10'd639, 10'd1};
    logic [9:0] ys[3] = '{10'd0, 10'd479, 10'd1};
    logic [5:0] want[3] = '{6'h3F, 6'h3F, 6'h00};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(xs[i], ys[i], 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      n_tests++;
      if (rgb !== want[i]) begin
        n_fail++;
        $display("FAIL border_%0d_%0d: rgb=%h want %h", xs[i], ys[i], rgb, want[i]);
      end
    end
  endtask
`endif

  initial begin
    resetn = 1'b0;
    x_px = 10'd0; y_px = 10'd0; activevideo = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    btn_next = 1'b0; btn_pause = 1'b0;
    model_reset();
    test_reset();
    test_autoadvance();
    test_pattern0();
    test_pause_step();
    test_pending_on_advance();
    test_pause_freeze();
    test_anim();
    test_reset_mid();
`ifdef VGA_BORDER_EN
    test_border();
`endif
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_sequencer.md
Name: vga_pattern_sequencer

Overview:
Sequences test-pattern generation for the 6-bit VGA output path. It sits between the VGA sync generator (x_px, y_px, activevideo, hsync, vsync) and the output pins. It selects one of four pattern datapaths and advances automatically every HOLD_FRAMES frames, or on a button step, switching only at frame boundaries. It registers the pixel and delays the syncs by one cycle so they stay aligned.

Parameters:
HOLD_FRAMES, 60, frames each pattern is held in RUN state (>=1)
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low, 0 = asserted high

Ports:
clk  in  1  pixel clock; all logic on rising edge
resetn  in  1  asynchronous active-low reset
x_px  in  10  current pixel column from the sync generator
y_px  in  10  current pixel row from the sync generator
activevideo  in  1  high inside the visible area
hsync_in  in  1  raw hsync from the sync generator
vsync_in  in  1  raw vsync from the sync generator
btn_next  in  1  synchronous level; rising edge requests a step to the next pattern
btn_pause  in  1  synchronous level; rising edge toggles RUN/PAUSE
rgb  out  6  registered pixel {r1,r0,g1,g0,b1,b0}
hsync_out  out  1  hsync_in delayed 1 cycle
vsync_out  out  1  vsync_in delayed 1 cycle
pattern_idx  out  2  current pattern number
paused  out  1  high in PAUSE state

Behaviour:
- Reset (async, resetn=0):
  - rgb=0, pattern_idx=0, paused=0 (RUN).
  - hold counter=0, anim counter=0, pending step=0.
  - hsync_out/vsync_out go to the inactive level (1 if SYNC_ACTIVE_LOW, else 0).
  - Button edge-detect registers reset to 0, so a button held through reset does not fire.
- Frame event: a one-cycle pulse when vsync_in transitions inactive->active, detected against a registered copy of vsync_in.
- States:
  - RUN -> PAUSE on a btn_pause rising edge; PAUSE -> RUN on the next one. The change is immediate, not frame-aligned.
- Hold counter, width clog2(HOLD_FRAMES)+1:
  - RUN: increments on each frame event.
  - On a frame event with counter==HOLD_FRAMES-1: counter clears to 0 and pattern_idx increments mod 4 (3 wraps to 0).
  - PAUSE: counter holds.
- Step request:
  - A btn_next rising edge sets pending=1 in either state.
  - On the next frame event: pattern_idx increments by exactly 1, the counter clears, pending clears.
  - An auto-advance and a pending step on the same frame event give a single increment.
  - Further btn_next edges while pending=1 are absorbed (no double step).
- Anim counter (8 bit): increments on each frame event in RUN, holds in PAUSE.
- Pattern datapath (combinational, then registered):
  - 0, threshold bars: r={y>300, y>150}, g={x>400, x>200}, b=00.
  - 1, colour bars: b3=x_px[8:6]; rgb={b3[2],b3[2],b3[1],b3[1],b3[0],b3[0]}.
  - 2, checkerboard: rgb = 6'h3F if x_px[5]^y_px[5], else 0.
  - 3, animated gradient: r=y_px[7:6], g=x_px[7:6], b=anim[7:6].
- rgb register loads the selected pattern when activevideo=1, otherwise 0. Latency is 1 cycle from x_px/y_px to rgb, matching the sync delay.
- pattern_idx changes only at frame events, never mid-frame.

Optional Feature:
VGA_BORDER_EN:
- Defined: when activevideo=1 and (x_px==0 or x_px==H_ACTIVE-1 or y_px==0 or y_px==V_ACTIVE-1), rgb is forced to 6'h3F in every pattern and state; same 1-cycle latency.
- Undefined: no border logic; rgb is the pattern output only.

Test Plan:
1. Reset, HOLD_FRAMES=2, run 8 frame events with no buttons -> pattern_idx sequence 0,0,1,1,2,2,3,3 then 0 (wrap); every rgb/hsync_out/vsync_out change lags its input by exactly 1 clk.
2. Pattern 0, activevideo=1, x=401, y=151 -> rgb=6'b011100 next cycle. With activevideo=0 at the same x,y -> rgb=0.
3. btn_next pulse mid-frame in PAUSE -> pattern_idx unchanged until the next vsync assertion, then +1. A second btn_next edge before that frame event -> still only +1.
4. HOLD_FRAMES=2: btn_next pending on the frame event where the counter==1 -> single increment, counter=0.
5. btn_pause edge -> paused=1 next cycle; 5 frame events -> pattern_idx and anim frozen. Second edge -> resumes from the same counter value.
6. resetn low mid-frame with pending=1 and pattern 3 -> immediately rgb=0, pattern_idx=0, pending cleared, syncs inactive. With VGA_BORDER_EN: pixel (0,0) and (639,479) -> 6'h3F, pixel (1,1) -> pattern value.
